// File: rtl/seg16_byte_pager.sv
// Byte pager for the 4-digit hex display: buffers bytes in a small FIFO and
// pops one per dwell period onto disp. Optional idle blanking: SEG16_PAGER_BLANK_EN.
module seg16_byte_pager #(
  parameter int DEPTH       = 4,
  parameter int DWELL       = 50_000_000,
  parameter int IDLE_CYCLES = 500_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [16:0]            disp,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_RELOAD = DW'(DWELL - 1);
  localparam logic [CW-1:0] FULL_CNT     = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [16:0]   disp_q, disp_d;
  logic          push, pop;

`ifdef SEG16_PAGER_BLANK_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  logic [IW-1:0] idle_q, idle_d;
`endif

  assign in_ready = !rst && !clr && (cnt_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  // Pop looks only at registered count, so a byte pushed into an empty FIFO waits one edge.
  assign pop      = (cnt_q != '0) && (dwell_q == '0);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    disp_d   = disp_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dwell_d  = DWELL_RELOAD;
      disp_d   = {1'b1, disp_q[7:0], mem_q[rd_ptr_q]};
    end else if (dwell_q != '0) begin
      dwell_d = dwell_q - DW'(1);
    end

`ifdef SEG16_PAGER_BLANK_EN
    idle_d = idle_q;
    if (pop)                    idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + IW'(1);
    // Blank on the edge the counter lands on its limit, keeping the digits underneath.
    if (!pop && (idle_d == IDLE_MAX)) disp_d[16] = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      disp_q   <= '0;
`ifdef SEG16_PAGER_BLANK_EN
      idle_q   <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      disp_q   <= disp_d;
`ifdef SEG16_PAGER_BLANK_EN
      idle_q   <= idle_d;
`endif
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign disp     = disp_q;
  assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_seg16_byte_pager.sv
// Self-checking bench for seg16_byte_pager: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_seg16_byte_pager;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int IDLE  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [16:0] disp;
  logic [2:0]  fifo_cnt;

  int checks = 0;
  int failures = 0;

  seg16_byte_pager #(.DEPTH(DEPTH), .DWELL(DWELL), .IDLE_CYCLES(IDLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .disp     (disp),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, the display a 17-bit value.
  logic [7:0]  m_q[$];
  logic [16:0] m_disp = '0;
  int          m_dwell = 0;
  int          m_idle = 0;
  bit          model_live = 0;

  always @(posedge clk) begin
    int         sz;
    bit         do_pop, do_push;
    logic [7:0] h;
    if (rst || clr) begin
      m_q.delete();
      m_disp  = '0;
      m_dwell = 0;
      m_idle  = 0;
    end else begin
      sz      = m_q.size();
      do_pop  = (sz != 0) && (m_dwell == 0);
      do_push = in_valid && (sz != DEPTH);
      if (do_pop) begin
        h       = m_q.pop_front();
        m_disp  = {1'b1, m_disp[7:0], h};
        m_dwell = DWELL - 1;
      end else if (m_dwell > 0) begin
        m_dwell--;
      end
`ifdef SEG16_PAGER_BLANK_EN
      if (do_pop) m_idle = 0;
      else if (m_idle < IDLE) m_idle++;
      if (!do_pop && m_idle == IDLE) m_disp[16] = 1'b0;
`endif
      if (do_push) m_q.push_back(in_data);
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("model_disp", {15'd0, disp}, {15'd0, m_disp});
      check("model_fifo_cnt", {29'd0, fifo_cnt}, m_q.size());
      check("model_in_ready", {31'd0, in_ready},
            {31'd0, (!rst && !clr && m_q.size() != DEPTH)});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [6];
    int         idx;
    bit         acc, saw_full, pending;

    // Reset state
    repeat (3) step();
    check("rst_disp", {15'd0, disp}, 32'h0);
    check("rst_cnt", {29'd0, fifo_cnt}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;

    // Single push: shown one edge after acceptance
    push_one(8'hA5);
    check("a5_cnt_after_push", {29'd0, fifo_cnt}, 32'd1);
    check("a5_disp_before_pop", {15'd0, disp}, 32'h0);
    step();
    check("a5_disp", {15'd0, disp}, 32'h100A5);
    check("a5_cnt_after_pop", {29'd0, fifo_cnt}, 32'd0);

    // Back-to-back pair: second byte exactly DWELL cycles after the first
    repeat (4) step();
    do_clr();
    in_valid = 1'b1; in_data = 8'h12; step();
    in_data = 8'h34; step();
    in_valid = 1'b0;
    check("pair_first", {15'd0, disp}, 32'h10012);
    repeat (3) step();
    check("pair_hold", {15'd0, disp}, 32'h10012);
    step();
    check("pair_second", {15'd0, disp}, 32'h11234);

    // Six bytes offered continuously while the dwell is running; source holds on !in_ready
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    idx = 0;
    saw_full = 0;
    for (int c = 0; c < 60 && idx < 6; c++) begin
      in_valid = 1'b1;
      in_data  = seq[idx];
      acc = in_ready;
      if (!in_ready && fifo_cnt == 3'd4) saw_full = 1;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("fill_all_accepted", idx, 32'd6);
    check("fill_saw_full", {31'd0, saw_full}, 32'd1);
    repeat (30) step();
    check("fill_drained", {29'd0, fifo_cnt}, 32'd0);
    check("fill_last_pair", {15'd0, disp}, 32'h10506);

    // clr with a push offered while three bytes are buffered
    do_clr();
    push_one(8'h11);
    push_one(8'h22);
    push_one(8'h33);
    push_one(8'h44);
    check("clr_pre_cnt", {29'd0, fifo_cnt}, 32'd3);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    check("clr_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_disp", {15'd0, disp}, 32'h0);
    check("clr_cnt", {29'd0, fifo_cnt}, 32'd0);
    repeat (6) step();
    check("clr_no_pops", {15'd0, disp}, 32'h0);

    // rst mid-dwell with two bytes buffered
    push_one(8'h11);
    push_one(8'h22);
    push_one(8'h33);
    check("rst_pre_cnt", {29'd0, fifo_cnt}, 32'd2);
    rst = 1'b1;
    step();
    check("rst_mid_disp", {15'd0, disp}, 32'h0);
    check("rst_mid_cnt", {29'd0, fifo_cnt}, 32'd0);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);

    // Idle behaviour after a single byte
    push_one(8'h7E);
    step();
    check("idle_shown", {15'd0, disp}, 32'h1007E);
    repeat (19) step();
    check("idle_before_limit", {15'd0, disp}, 32'h1007E);
    step();
`ifdef SEG16_PAGER_BLANK_EN
    check("idle_blanked", {15'd0, disp}, 32'h0007E);
`else
    check("idle_kept", {15'd0, disp}, 32'h1007E);
`endif
    repeat (5) step();
`ifdef SEG16_PAGER_BLANK_EN
    check("idle_still_blank", {15'd0, disp}, 32'h0007E);
`else
    check("idle_still_kept", {15'd0, disp}, 32'h1007E);
`endif

    // Random traffic with source-hold honoured; the model checks every cycle
    pending = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 99) == 0);
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      #1;
      acc = in_valid && in_ready;
      pending = in_valid && !acc;
      step();
    end
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
